// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice (A1/B1/M/P/OPMODE registered) as a length-N dot-product engine.
// Operand pairs stream in over valid/ready; the accumulated P is captured once the pipeline drains.
module dsp_mac_sequencer #(
    parameter int LEN_W  = 8,
    parameter int OP_DLY = 1,
    parameter int P_LAT  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [17:0]      in_a_i,
    input  logic [17:0]      in_b_i,
    output logic [17:0]      dsp_a_o,
    output logic [17:0]      dsp_b_o,
    output logic [7:0]       dsp_opmode_o,
    output logic             dsp_ce_o,
    output logic             dsp_rst_o,
    input  logic [47:0]      dsp_p_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [47:0]      result_o
);

    // state | meaning
    // IDLE  | waiting for start
    // CLR   | one cycle of slice reset, clears any previous P
    // RUN   | accepting operand pairs, slice advances only on a pair
    // DRAIN | feeding zero products until the last product reaches P
    // DONE  | result held until the consumer takes it
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h00;
    localparam int         DCW      = (P_LAT > 1) ? $clog2(P_LAT) : 1;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             first_q, first_d;
    logic [47:0]      result_q, result_d;

    logic [17:0] dsp_a_c, dsp_b_c;
    logic [7:0]  op_in_c;
    logic        ce_c, dsp_rst_c, op_clr_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            drain_q  <= '0;
            first_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            drain_q  <= drain_d;
            first_q  <= first_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        first_d   = first_q;
        result_d  = result_q;
        dsp_a_c   = '0;
        dsp_b_c   = '0;
        op_in_c   = OP_HOLD;
        ce_c      = 1'b0;
        dsp_rst_c = 1'b0;
        op_clr_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        rem_d   = len_i;
                        state_d = S_CLR;
                    end else begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CLR: begin
                dsp_rst_c = 1'b1;
                op_clr_c  = 1'b1;
                first_d   = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (in_valid_i) begin
                    dsp_a_c = in_a_i;
                    dsp_b_c = in_b_i;
                    ce_c    = 1'b1;
                    op_in_c = first_q ? OP_FIRST : OP_ACC;
                    first_d = 1'b0;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        drain_d = DCW'(P_LAT - 1);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ce_c    = 1'b1;
                op_in_c = OP_ACC;
                if (drain_q == '0) begin
                    result_d = dsp_p_i;
                    state_d  = S_DONE;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset must reach the slice immediately, not one edge later.
        if (rst_i) begin
            dsp_a_c   = '0;
            dsp_b_c   = '0;
            ce_c      = 1'b0;
            dsp_rst_c = 1'b1;
        end
    end

    generate
        if (OP_DLY == 0) begin : g_op_direct
            assign dsp_opmode_o = ce_c ? op_in_c : OP_HOLD;
        end else begin : g_op_delay
            logic [OP_DLY-1:0][7:0] opdl_q;
            always_ff @(posedge clk_i) begin
                if (rst_i || op_clr_c) begin
                    opdl_q <= '0;
                end else if (ce_c) begin
                    opdl_q[0] <= op_in_c;
                    for (int i = 1; i < OP_DLY; i++) opdl_q[i] <= opdl_q[i-1];
                end
            end
            assign dsp_opmode_o = opdl_q[OP_DLY-1];
        end
    endgenerate

    assign dsp_a_o     = dsp_a_c;
    assign dsp_b_o     = dsp_b_c;
    assign dsp_ce_o    = ce_c;
    assign dsp_rst_o   = dsp_rst_c;
    assign busy_o      = (state_q != S_IDLE);
    assign in_ready_o  = (state_q == S_RUN);
    assign res_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registers, common CE and RST) attached to its slice ports.
module tb_dsp_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [17:0] in_a = '0, in_b = '0;
    logic        res_ready = 1'b0;
    logic        busy, in_ready, dsp_ce, dsp_rst, res_valid;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p, result;

    int total = 0, passed = 0, failed = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(8), .OP_DLY(1), .P_LAT(3)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .busy_o(busy),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_opmode_o(dsp_opmode),
        .dsp_ce_o(dsp_ce), .dsp_rst_o(dsp_rst), .dsp_p_i(dsp_p),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .result_o(result)
    );

    // Slice model: P = X + Z with X from OPMODE[1:0] (01 = M) and Z from OPMODE[3:2] (10 = P)
    logic signed [17:0] s_a1, s_b1;
    logic signed [35:0] s_m;
    logic        [7:0]  s_op;
    logic        [47:0] s_p;
    always_ff @(posedge clk) begin
        if (dsp_rst) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_op <= '0; s_p <= '0;
        end else if (dsp_ce) begin
            s_a1 <= dsp_a;
            s_b1 <= dsp_b;
            s_m  <= s_a1 * s_b1;
            s_op <= dsp_opmode;
            s_p  <= ((s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0)
                  + ((s_op[3:2] == 2'b10) ? s_p : 48'd0);
        end
    end
    assign dsp_p = s_p;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [17:0] a, input logic [17:0] b, input int ngap);
        for (int g = 0; g < ngap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("gap_ce", {47'd0, dsp_ce}, 48'd0);
            step();
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 40 && !in_ready; k++) step();
        check("in_ready_wait", {47'd0, in_ready}, 48'd1);
        @(negedge clk);
        check("adv_ce", {47'd0, dsp_ce}, 48'd1);
        check("adv_a", {30'd0, dsp_a}, {30'd0, a});
        step();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [47:0] exp, input bit poke_start);
        for (int k = 0; k < 40 && !res_valid; k++) step();
        check({tag, "_valid"}, {47'd0, res_valid}, 48'd1);
        check(tag, result, exp);
        step();
        step();
        check({tag, "_hold_v"}, {47'd0, res_valid}, 48'd1);
        check({tag, "_hold_r"}, result, exp);
        if (poke_start) begin
            start_job(8'd1);
            check({tag, "_start_ign_busy"}, {47'd0, busy}, 48'd1);
            check({tag, "_start_ign_v"}, {47'd0, res_valid}, 48'd1);
            check({tag, "_start_ign_r"}, result, exp);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_ack_v"}, {47'd0, res_valid}, 48'd0);
        check({tag, "_ack_busy"}, {47'd0, busy}, 48'd0);
        step();
        check({tag, "_idle_busy"}, {47'd0, busy}, 48'd0);
    endtask

    initial begin
        // T1 reset
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_dsp_rst", {47'd0, dsp_rst}, 48'd1);
        check("rst_ce", {47'd0, dsp_ce}, 48'd0);
        check("rst_a", {30'd0, dsp_a}, 48'd0);
        check("rst_opmode", {40'd0, dsp_opmode}, 48'd0);
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_res_valid", {47'd0, res_valid}, 48'd0);
        check("rst_result", result, 48'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", {47'd0, busy}, 48'd0);
        check("post_rst_ready", {47'd0, in_ready}, 48'd0);
        check("post_rst_dsp_rst", {47'd0, dsp_rst}, 48'd0);

        // T2 dot product without bubbles: 200 + 30 - 21 = 209
        start_job(8'd3);
        check("t2_busy", {47'd0, busy}, 48'd1);
        push(18'd20, 18'd10, 0);
        push(18'd5, 18'd6, 0);
        push(-18'sd3, 18'd7, 0);
        get_result("t2_result", 48'd209, 1'b0);

        // T3 same job with bubbles
        start_job(8'd3);
        push(18'd20, 18'd10, 2 + $urandom_range(0, 2));
        push(18'd5, 18'd6, 2 + $urandom_range(0, 2));
        push(-18'sd3, 18'd7, 2 + $urandom_range(0, 2));
        get_result("t3_result", 48'd209, 1'b0);

        // T4 zero-length job
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        check("t4_ce_start", {47'd0, dsp_ce}, 48'd0);
        step();
        start = 1'b0;
        check("t4_valid", {47'd0, res_valid}, 48'd1);
        check("t4_result", result, 48'd0);
        @(negedge clk);
        check("t4_ce_done", {47'd0, dsp_ce}, 48'd0);
        check("t4_dsp_rst", {47'd0, dsp_rst}, 48'd0);
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t4_ack_v", {47'd0, res_valid}, 48'd0);

        // T5 back-to-back, start during DONE ignored
        start_job(8'd1);
        push(18'd2, 18'd3, 0);
        get_result("t5_first", 48'd6, 1'b1);
        start_job(8'd1);
        push(18'd4, 18'd4, 0);
        get_result("t5_second", 48'd16, 1'b0);

        // T6 abort mid-RUN, then a fresh job
        start_job(8'd4);
        push(18'd1, 18'd2, 0);
        push(18'd3, 18'd4, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_dsp_rst", {47'd0, dsp_rst}, 48'd1);
        check("t6_rst_ce", {47'd0, dsp_ce}, 48'd0);
        step();
        rst = 1'b0;
        check("t6_busy", {47'd0, busy}, 48'd0);
        check("t6_res_valid", {47'd0, res_valid}, 48'd0);
        check("t6_ready", {47'd0, in_ready}, 48'd0);
        start_job(8'd1);
        push(18'd7, 18'd8, 0);
        get_result("t6_result", 48'd56, 1'b0);

        // Signed result wraps into 48-bit two's complement: -15 + 2 = -13
        start_job(8'd2);
        push(-18'sd5, 18'd3, 1);
        push(18'd2, 18'd1, 0);
        get_result("neg_result", 48'hFFFF_FFFF_FFF3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
